// File: rtl/des_key_schedule_if.sv
// -----------------------------------------------------------------------------
// des_key_schedule_if
// Handshake bundle between the DES round datapath (master) and the subkey
// generator (slave).
//   start        : load key / sample decrypt, begin a schedule (master -> slave)
//   decrypt      : 0 = K1..K16, 1 = K16..K1, sampled with start
//   key[63:0]    : DES key, FIPS bit 1 = key[63], parity bits ignored
//   adv          : current subkey consumed, step to the next one
//   subkey[47:0] : current subkey, FIPS bit 1 = subkey[47], 0 when invalid
//   subkey_valid : subkey is meaningful for round `round`
//   round[3:0]   : subkeys consumed so far in this schedule
//   busy         : schedule in progress
//   done         : one-cycle pulse after the 16th subkey is consumed
// -----------------------------------------------------------------------------
interface des_key_schedule_if;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        adv;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, key, adv,
        input  subkey, subkey_valid, round, busy, done
    );

    modport slave (
        input  start, decrypt, key, adv,
        output subkey, subkey_valid, round, busy, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Sequential DES subkey generator. PC-1 on start, then walks C/D forward
// (encryption, left rotations) or backward (decryption, right rotations), one
// step per accepted `adv`. The subkey is PC-2 of the registered C/D, so every
// output is a function of registers only.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   ks   : des_key_schedule_if.slave (start/decrypt/key/adv in,
//          subkey/subkey_valid/round/busy/done out)
// -----------------------------------------------------------------------------
module des_key_schedule (
    input  logic                 clk,
    input  logic                 rst,
    des_key_schedule_if.slave    ks
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // FIPS 46-3 permutation tables, 1-based source bit numbers.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit j set when round j of the schedule rotates by 2 (else by 1).
    // s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
    localparam logic [16:1] SHIFT2 = 16'h7EFC;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47 - i] = cd[56 - PC2[i]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;

    logic [55:0] cd0;
    logic [4:0]  fwd_idx;
    logic [4:0]  bwd_idx;
    logic        rot_two;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        cd0     = pc1(ks.key);
        // Encryption steps into K(round+2); decryption steps out of K(16-round).
        fwd_idx = {1'b0, round_q} + 5'd2;
        bwd_idx = 5'd16 - {1'b0, round_q};
        rot_two = dir_q ? SHIFT2[bwd_idx] : SHIFT2[fwd_idx];

        if (ks.start) begin
            // Start wins over a concurrent adv and restarts from any state.
            // Decryption loads C0/D0 directly: the total rotation is 28, so
            // they equal C16/D16 and give K16 first.
            if (ks.decrypt) begin
                c_d = cd0[55:28];
                d_d = cd0[27:0];
            end else begin
                c_d = rol28(cd0[55:28], 1'b0);
                d_d = rol28(cd0[27:0], 1'b0);
            end
            dir_d   = ks.decrypt;
            round_d = '0;
            state_d = ACTIVE;
        end else if (state_q == ACTIVE && ks.adv) begin
            if (round_q == 4'd15) begin
                state_d = IDLE;
                round_d = '0;
                done_d  = 1'b1;
            end else begin
                if (dir_q) begin
                    c_d = ror28(c_q, rot_two);
                    d_d = ror28(d_q, rot_two);
                end else begin
                    c_d = rol28(c_q, rot_two);
                    d_d = rol28(d_q, rot_two);
                end
                round_d = round_q + 4'd1;
            end
        end
    end

    assign ks.subkey_valid = (state_q == ACTIVE);
    assign ks.busy         = (state_q == ACTIVE);
    assign ks.subkey       = (state_q == ACTIVE) ? pc2({c_q, d_q}) : '0;
    assign ks.round        = round_q;
    assign ks.done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1
// key and its hand-derived subkeys, plus weak key FEFEFEFEFEFEFEFE whose
// subkeys are all ones.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

    logic clk;
    logic rst;

    des_key_schedule_if ksif ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ksif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_W = 64'hFEFEFEFEFEFEFEFE;

    logic [47:0] ks_a [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Step one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"},  ksif.subkey_valid, 0);
        chk({tag, "_busy"}, ksif.busy, 0);
        chk({tag, "_rnd"},  ksif.round, 0);
        chk({tag, "_done"}, ksif.done, 0);
        chk({tag, "_key"},  ksif.subkey, 0);
    endtask

    task automatic begin_sched(input logic [63:0] k, input logic dec);
        ksif.key     = k;
        ksif.decrypt = dec;
        ksif.start   = 1'b1;
        tick();
        ksif.start   = 1'b0;
        ksif.decrypt = ~dec;      // must be ignored outside start
        ksif.key     = ~k;
    endtask

    // Full schedule of KEY_A with adv held high.
    task automatic run_full(input string tag, input logic dec);
        begin_sched(KEY_A, dec);
        ksif.adv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_key"}, ksif.subkey, dec ? ks_a[15 - i] : ks_a[i]);
            chk({tag, "_rnd"}, ksif.round, i);
            chk({tag, "_vld"}, ksif.subkey_valid, 1);
            tick();
        end
        ksif.adv = 1'b0;
        chk({tag, "_done"},     ksif.done, 1);
        chk({tag, "_end_vld"},  ksif.subkey_valid, 0);
        chk({tag, "_end_key"},  ksif.subkey, 0);
        chk({tag, "_end_rnd"},  ksif.round, 0);
        tick();
        chk({tag, "_done_low"}, ksif.done, 0);
    endtask

    initial begin
        int cnt;
        rst          = 1'b1;
        ksif.start   = 1'b1;
        ksif.decrypt = 1'b0;
        ksif.key     = KEY_A;
        ksif.adv     = 1'b0;

        // Reset dominates a held start.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("rst");
        end
        rst        = 1'b0;
        ksif.start = 1'b0;
        tick();
        chk_idle("post_rst");

        run_full("enc", 1'b0);
        run_full("dec", 1'b0 | 1'b1);

        // Stalls: adv pattern 1,0,0 repeating.
        begin_sched(KEY_A, 1'b0);
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 16; cyc++) begin
            chk("stall_key", ksif.subkey, ks_a[cnt]);
            chk("stall_rnd", ksif.round, cnt);
            ksif.adv = (cyc % 3 == 0);
            tick();
            if (ksif.adv) cnt++;
        end
        ksif.adv = 1'b0;
        chk("stall_cnt",  cnt, 16);
        chk("stall_done", ksif.done, 1);
        chk("stall_vld",  ksif.subkey_valid, 0);
        tick();

        // Mid-schedule restart with a concurrent adv.
        begin_sched(KEY_A, 1'b0);
        ksif.adv = 1'b1;
        repeat (5) tick();
        chk("rs_pre_rnd", ksif.round, 5);
        chk("rs_pre_key", ksif.subkey, ks_a[5]);
        ksif.key     = KEY_W;
        ksif.decrypt = 1'b1;
        ksif.start   = 1'b1;
        tick();
        ksif.start = 1'b0;
        ksif.adv   = 1'b0;
        chk("rs_rnd",  ksif.round, 0);
        chk("rs_key",  ksif.subkey, 48'hFFFFFFFFFFFF);
        chk("rs_vld",  ksif.subkey_valid, 1);
        chk("rs_done", ksif.done, 0);
        // Second restart back onto KEY_A, adv again concurrent: must show K1.
        ksif.key     = KEY_A;
        ksif.decrypt = 1'b0;
        ksif.start   = 1'b1;
        ksif.adv     = 1'b1;
        tick();
        ksif.start = 1'b0;
        chk("rs2_rnd", ksif.round, 0);
        chk("rs2_key", ksif.subkey, ks_a[0]);
        tick();
        chk("rs2_next", ksif.subkey, ks_a[1]);

        // Reset mid-operation at round 9.
        repeat (8) tick();
        chk("mr_pre_rnd", ksif.round, 9);
        chk("mr_pre_key", ksif.subkey, ks_a[9]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mr");
        tick();
        chk_idle("mr_hold");
        ksif.adv = 1'b0;

        run_full("after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
